// File: rtl/button_pkg.sv
// button_pkg: shared definitions for the button event path.
//   state_e      output-stage states of the event arbiter
//   EV_RELEASE / EV_PRESS   event-kind encodings carried on ev_press
//   N_MIN / N_MAX           supported range of debounced channel counts
package button_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    localparam logic EV_RELEASE = 1'b0;
    localparam logic EV_PRESS   = 1'b1;

    localparam int unsigned N_MIN = 2;
    localparam int unsigned N_MAX = 16;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin priority selector.
//   req  in  N   request vector
//   ptr  in  CW  highest-priority index (must be < N)
//   any  out 1   at least one request set
//   idx  out CW  first set request searching ptr, ptr+1, ... mod N
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned CW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [CW-1:0] ptr,
    output logic          any,
    output logic [CW-1:0] idx
);

    localparam logic [CW:0] NW = (CW + 1)'(N);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [CW-1:0]  off;
    logic [CW:0]    sum;

    // Rotate so that bit 0 of rot is the request at ptr.
    assign dbl = {req, req};
    assign rot = N'(dbl >> ptr);

    always_comb begin
        off = '0;
        // Descending scan: the lowest set offset is written last and wins.
        for (int k = int'(N) - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = CW'(k);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        idx = (sum >= NW) ? CW'(sum - NW) : CW'(sum);
        any = |req;
    end

endmodule

// File: rtl/button_event_arbiter.sv
// button_event_arbiter: serialises debounced press/release events from N
// channels onto one valid/ready stream, granting channels round-robin.
//   clk       in  1   system clock
//   reset     in  1   asynchronous active-high reset
//   db_level  in  N   debounced level per channel
//   db_tick   in  N   one-cycle press pulse per channel
//   ev_valid  out 1   event available (registered)
//   ev_ready  in  1   consumer accepts on ev_valid & ev_ready
//   ev_chan   out CW  channel of presented event (registered)
//   ev_press  out 1   1 = press, 0 = release (registered)
//   overrun   out 1   sticky: an unissued event was overwritten
//   ovr_clr   in  1   synchronous clear of overrun (a same-cycle set wins)
module button_event_arbiter
    import button_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned CW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  db_level,
    input  logic [N-1:0]  db_tick,
    output logic          ev_valid,
    input  logic          ev_ready,
    output logic [CW-1:0] ev_chan,
    output logic          ev_press,
    output logic          overrun,
    input  logic          ovr_clr
);

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [N-1:0]  lvl_q;
    logic [N-1:0]  pend_q, pend_d;
    logic [N-1:0]  kind_q, kind_d;
    logic [N-1:0]  rel, arrive, grant_vec;
    state_e        state_q, state_d;
    logic [CW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] chan_q, chan_d;
    logic          press_q, press_d;
    logic          overrun_q, overrun_d;
    logic          pick_any, grant, ovr_set;
    logic [CW-1:0] pick_idx;

    rr_pick #(
        .N  (N),
        .CW (CW)
    ) u_rr_pick (
        .req (pend_q),
        .ptr (rr_ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign rel    = lvl_q & ~db_level;
    assign arrive = db_tick | rel;

    // The output register can take a new event when empty or when the
    // current one is being accepted this cycle.
    assign grant = pick_any & ((state_q == ST_EMPTY) | ev_ready);

    always_comb begin
        pend_d  = pend_q;
        kind_d  = kind_q;
        ovr_set = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            grant_vec[i] = grant && (pick_idx == CW'(i));
            if (grant_vec[i]) begin
                pend_d[i] = 1'b0;
            end
            if (arrive[i]) begin
                // A slot being granted this cycle is free to reload.
                if (pend_q[i] && !grant_vec[i]) begin
                    ovr_set = 1'b1;
                end
                pend_d[i] = 1'b1;
                kind_d[i] = db_tick[i] ? EV_PRESS : EV_RELEASE;
            end
        end
        overrun_d = ovr_set | (overrun_q & ~ovr_clr);
    end

    always_comb begin
        state_d  = state_q;
        chan_d   = chan_q;
        press_d  = press_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            ST_EMPTY: if (pick_any) state_d = ST_FULL;
            ST_FULL:  if (ev_ready && !pick_any) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
        if (grant) begin
            chan_d   = pick_idx;
            press_d  = kind_q[pick_idx];
            rr_ptr_d = (pick_idx == LAST) ? '0 : pick_idx + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lvl_q     <= '0;
            pend_q    <= '0;
            kind_q    <= '0;
            state_q   <= ST_EMPTY;
            rr_ptr_q  <= '0;
            chan_q    <= '0;
            press_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            lvl_q     <= db_level;
            pend_q    <= pend_d;
            kind_q    <= kind_d;
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            chan_q    <= chan_d;
            press_q   <= press_d;
            overrun_q <= overrun_d;
        end
    end

    assign ev_valid = (state_q == ST_FULL);
    assign ev_chan  = chan_q;
    assign ev_press = press_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
module tb_button_event_arbiter;

    localparam int N  = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  db_level;
    logic [N-1:0]  db_tick;
    logic          ev_valid;
    logic          ev_ready;
    logic [CW-1:0] ev_chan;
    logic          ev_press;
    logic          overrun;
    logic          ovr_clr;

    typedef struct packed {
        logic [CW-1:0] chan;
        logic          press;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    button_event_arbiter #(
        .N (N)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .db_level (db_level),
        .db_tick  (db_tick),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_chan  (ev_chan),
        .ev_press (ev_press),
        .overrun  (overrun),
        .ovr_clr  (ovr_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int ch, input bit pr);
        exp_t e;
        e.chan  = CW'(ch);
        e.press = pr;
        sb.push_back(e);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || ev_valid) && n < 100) begin
            cyc();
            n++;
        end
        check(name, n < 100 ? 1 : 0, 1);
    endtask

    // Monitor: every accepted transfer is compared against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && ev_valid && ev_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_event", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("ev_chan", int'(ev_chan), int'(e.chan));
                    check("ev_press", int'(ev_press), int'(e.press));
                end
            end
        end
    end

    initial begin
        bit stable;
        bit quiet;
        reset    = 1'b1;
        db_level = '0;
        db_tick  = '0;
        ev_ready = 1'b1;
        ovr_clr  = 1'b0;
        cyc();
        cyc();
        check("rst_valid", int'(ev_valid), 0);
        check("rst_chan", int'(ev_chan), 0);
        check("rst_press", int'(ev_press), 0);
        check("rst_overrun", int'(overrun), 0);
        reset = 1'b0;
        cyc();

        // Single press on ch 2: valid two edges after the pulse, one transfer.
        db_tick = 4'b0100;
        push(2, 1'b1);
        cyc();
        db_tick = '0;
        check("press_lat1_valid", int'(ev_valid), 0);
        cyc();
        check("press_lat2_valid", int'(ev_valid), 1);
        cyc();
        check("press_done_valid", int'(ev_valid), 0);

        // Level rise without a tick is not an event; the fall is a release.
        db_level[1] = 1'b1;
        repeat (3) cyc();
        check("no_spurious_press", int'(ev_valid), 0);
        db_level[1] = 1'b0;
        push(1, 1'b0);
        cyc();
        check("rel_lat1_valid", int'(ev_valid), 0);
        cyc();
        check("rel_lat2_valid", int'(ev_valid), 1);
        cyc();
        check("rel_done_valid", int'(ev_valid), 0);

        // ch 3 press leaves rr_ptr at 0.
        db_tick = 4'b1000;
        push(3, 1'b1);
        cyc();
        db_tick = '0;
        drain("drain_ch3");

        // Round robin: 0,1,3 back to back.
        db_tick = 4'b1011;
        push(0, 1'b1);
        push(1, 1'b1);
        push(3, 1'b1);
        cyc();
        db_tick = '0;
        cyc();
        check("rr_b2b_valid0", int'(ev_valid), 1);
        cyc();
        check("rr_b2b_valid1", int'(ev_valid), 1);
        cyc();
        check("rr_b2b_valid2", int'(ev_valid), 1);
        cyc();
        check("rr_b2b_end", int'(ev_valid), 0);
        // Pointer wrapped to 0 after ch 3: ch 0 before ch 3.
        db_tick = 4'b1001;
        push(0, 1'b1);
        push(3, 1'b1);
        cyc();
        db_tick = '0;
        drain("drain_rr_wrap");

        // Backpressure with an overwrite of a pending ch 2 release.
        ev_ready    = 1'b0;
        db_tick     = 4'b0100;
        db_level[2] = 1'b1;
        push(2, 1'b1);
        cyc();
        db_tick = '0;
        cyc();
        check("bp_valid", int'(ev_valid), 1);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) db_level[2] = 1'b0;
            if (i == 10) begin
                db_tick[2]  = 1'b1;
                db_level[2] = 1'b1;
            end
            if (i == 11) db_tick = '0;
            if (i == 10) check("ovr_before", int'(overrun), 0);
            cyc();
            if (!(ev_valid && ev_chan == 2'd2 && ev_press)) stable = 1'b0;
        end
        push(2, 1'b1);
        check("bp_stable", int'(stable), 1);
        check("ovr_set", int'(overrun), 1);
        ev_ready = 1'b1;
        drain("drain_bp");
        check("ovr_sticky", int'(overrun), 1);
        ovr_clr = 1'b1;
        cyc();
        ovr_clr = 1'b0;
        check("ovr_cleared", int'(overrun), 0);

        // Grant of ch 0 coincides with arrival of its release.
        db_tick[0]  = 1'b1;
        db_level[0] = 1'b1;
        push(0, 1'b1);
        push(0, 1'b0);
        cyc();
        db_tick     = '0;
        db_level[0] = 1'b0;
        drain("drain_collision");
        check("collision_no_ovr", int'(overrun), 0);

        // Reset while FULL with three pending and overrun set.
        ev_ready = 1'b0;
        db_tick  = 4'b1111;
        cyc();
        db_tick = '0;
        cyc();
        db_tick = 4'b0100;
        cyc();
        db_tick = '0;
        cyc();
        check("pre_rst_valid", int'(ev_valid), 1);
        check("pre_rst_ovr", int'(overrun), 1);
        reset = 1'b1;
        sb.delete();
        #1;
        check("mid_rst_valid", int'(ev_valid), 0);
        check("mid_rst_ovr", int'(overrun), 0);
        check("mid_rst_chan", int'(ev_chan), 0);
        cyc();
        reset    = 1'b0;
        ev_ready = 1'b1;
        quiet    = 1'b1;
        repeat (10) begin
            cyc();
            if (ev_valid) quiet = 1'b0;
        end
        check("no_stale_events", int'(quiet), 1);
        check("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
